// File: rtl/digest_fifo.sv
// Byte FIFO buffering digest bytes and releasing them in CAN-payload bursts; status flags decode from the registered count.
// Define DIGEST_FIFO_FWFT_EN for first-word fall-through reads; default is a registered read with 1-cycle latency.
module digest_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int BURST_LEN = 8,
  parameter int AF_THRESH = 28,
  parameter int AE_THRESH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              burst_rdy,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_C    = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_C    = AE_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] BURST_C = BURST_LEN[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              rd_ok, wr_ok;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign burst_rdy    = (count_q >= BURST_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // A full FIFO still takes a write when a read frees the slot on the same edge.
  assign rd_ok = rd && !empty;
  assign wr_ok = wr && (!full || rd_ok);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + 1'b1;
      if (rd_ok) rptr_d = rptr_q + 1'b1;
      count_d = count_q + {{ADDR_W{1'b0}}, wr_ok} - {{ADDR_W{1'b0}}, rd_ok};
      if (wr && !wr_ok) ovf_d = 1'b1;
      if (rd && !rd_ok) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush && wr_ok) mem[wptr_q] <= din;
  end

`ifdef DIGEST_FIFO_FWFT_EN
  // Gate on empty so dout reads 0 out of reset instead of stale array contents.
  assign dout  = empty ? '0 : mem[rptr_q];
  assign valid = !empty;
`else
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;

  always_comb begin
    dout_d  = dout_q;
    valid_d = 1'b0;
    if (rd_ok && !flush) begin
      dout_d  = mem[rptr_q];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;
`endif

endmodule

// File: tb/tb_digest_fifo.sv
// Directed bench for digest_fifo with a queue reference; covers burst, full/overflow, underflow, flush, wrap and reset.
module tb_digest_fifo;
  logic       clk = 1'b0;
  logic       rst, flush, wr, rd, err_clr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       valid, empty, full, almost_full, almost_empty, burst_rdy;
  logic [5:0] count;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];

  digest_fifo dut (
    .clk(clk), .rst(rst), .flush(flush), .wr(wr), .din(din), .rd(rd),
    .dout(dout), .valid(valid), .empty(empty), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .burst_rdy(burst_rdy), .count(count), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [7:0] d);
    wr = 1'b1; din = d;
    step();
    wr = 1'b0;
    q.push_back(d);
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    e = q.pop_front();
`ifdef DIGEST_FIFO_FWFT_EN
    chk({tag, "_dout"}, dout, e);
    chk({tag, "_valid"}, valid, 1);
`endif
    rd = 1'b1;
    step();
    rd = 1'b0;
`ifndef DIGEST_FIFO_FWFT_EN
    chk({tag, "_dout"}, dout, e);
    chk({tag, "_valid"}, valid, 1);
`endif
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_ae"}, almost_empty, 1);
    chk({tag, "_af"}, almost_full, 0);
    chk({tag, "_burst"}, burst_rdy, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_udf"}, underflow, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_dout"}, dout, 0);
  endtask

  initial begin
    int nw, nr, wraps;
    logic do_wr, do_rd;
    logic [7:0] d, e;

    rst = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; din = 8'h00;
    step(); step();
    check_reset("rst0");
    rst = 1'b1;

    // one CAN payload in, then out in order
    for (int i = 0; i < 8; i++) begin
      wr_word(8'(i));
      if (i == 6) chk("burst_at7", burst_rdy, 0);
    end
    chk("burst_count", count, 8);
    chk("burst_rdy", burst_rdy, 1);
    chk("burst_ae", almost_empty, 0);
    for (int i = 0; i < 8; i++) pop_chk("burst_pop");
    chk("burst_empty", empty, 1);
    step();
    chk("idle_valid", valid, 0);

    // fill to full and probe thresholds
    for (int i = 0; i < 32; i++) begin
      wr_word(8'h40 + 8'(i));
      if (count == 4)  chk("ae_at4", almost_empty, 1);
      if (count == 5)  chk("ae_at5", almost_empty, 0);
      if (count == 27) chk("af_at27", almost_full, 0);
      if (count == 28) chk("af_at28", almost_full, 1);
      if (count == 31) chk("full_at31", full, 0);
      if (count == 32) chk("full_at32", full, 1);
    end
    wr = 1'b1; din = 8'hAA;
    step();
    wr = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 32);

    // simultaneous write and read while full
    e = q.pop_front();
`ifdef DIGEST_FIFO_FWFT_EN
    chk("full_wr_rd_dout", dout, e);
`endif
    wr = 1'b1; rd = 1'b1; din = 8'hBB;
    step();
    wr = 1'b0; rd = 1'b0;
`ifndef DIGEST_FIFO_FWFT_EN
    chk("full_wr_rd_dout", dout, e);
`endif
    q.push_back(8'hBB);
    chk("full_wr_rd_count", count, 32);
    chk("full_wr_rd_full", full, 1);
    while (q.size() > 0) pop_chk("drain");
    chk("drain_empty", empty, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    // underflow from empty
    rd = 1'b1; step(); rd = 1'b0;
    chk("udf_set", underflow, 1);
    chk("udf_count", count, 0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("udf_clr", underflow, 0);

    // write+read on empty: write lands, read rejected
    wr = 1'b1; rd = 1'b1; din = 8'h5C;
    step();
    wr = 1'b0; rd = 1'b0;
    q.push_back(8'h5C);
    chk("empty_wr_rd_count", count, 1);
    chk("empty_wr_rd_udf", underflow, 1);
    pop_chk("empty_wr_rd_pop");
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // flush beats a concurrent write
    for (int i = 0; i < 10; i++) wr_word(8'h10 + 8'(i));
    chk("pre_flush_count", count, 10);
    flush = 1'b1; wr = 1'b1; din = 8'hEE;
    step();
    flush = 1'b0; wr = 1'b0;
    q.delete();
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_ovf", overflow, 0);
    chk("flush_udf", underflow, 0);
    err_clr = 1'b1; rd = 1'b1;
    step();
    err_clr = 1'b0; rd = 1'b0;
    chk("set_wins_udf", underflow, 1);
    chk("set_wins_count", count, 0);

    // random interleave with occupancy held at 3..29
    nw = 0; nr = 0; wraps = 0;
    for (int cyc = 0; cyc < 2000 && nr < 100; cyc++) begin
      do_wr = (nw < 100) && (q.size() < 29) && ((q.size() < 3) || ($urandom_range(0, 1) == 1));
      do_rd = (q.size() > 0) && ((q.size() > 3) || (nw == 100)) && ($urandom_range(0, 1) == 1);
      d = 8'($urandom_range(0, 255));
      e = (q.size() > 0) ? q[0] : 8'h00;
`ifdef DIGEST_FIFO_FWFT_EN
      if (do_rd) chk("wrap_dout", dout, e);
`endif
      wr = do_wr; rd = do_rd; din = d;
      step();
      wr = 1'b0; rd = 1'b0;
      if (do_rd) begin
        void'(q.pop_front());
        nr++;
`ifndef DIGEST_FIFO_FWFT_EN
        chk("wrap_dout", dout, e);
        chk("wrap_valid", valid, 1);
`endif
      end
      if (do_wr) begin
        q.push_back(d);
        nw++;
        if (nw % 32 == 0) wraps++;
      end
      chk("wrap_count", count, q.size());
    end
    chk("wrap_reads", nr, 100);
    chk("wrap_writes", nw, 100);
    chk("wrap_ptr_wraps", (wraps >= 3), 1);

    // reset in the middle of a burst
    for (int i = 0; i < 5; i++) wr_word(8'h60 + 8'(i));
    chk("mid_count", count, 5);
    rst = 1'b0; wr = 1'b1; rd = 1'b1; din = 8'hFF;
    step();
    rst = 1'b1; wr = 1'b0; rd = 1'b0;
    q.delete();
    check_reset("rst_mid");
    wr_word(8'h77);
    chk("post_rst_count", count, 1);
    pop_chk("post_rst_pop");
    chk("post_rst_empty", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
